pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage_pkg.sv | 23 ++
 rtl/pc_fetch_stage_pc_register.sv | 33 +++
 rtl/pc_fetch_stage.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//
// Contents:
//   RESET_PC_DEFAULT - PC loaded while rst_n is low (default for the top's RESET_PC)
//   PC_INCREMENT     - byte distance between sequential instructions
//   fetch_state_e    - fetch FSM states
package pc_fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INCREMENT     = 32'd4;

   // FETCH   : request is presented to instruction memory
   // WAIT    : request accepted, waiting for the response
   // HOLD    : response captured while decode was stalled
   // DISCARD : a squashed request is still in flight; its response is dropped
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_stage_pc_register.sv
// Program counter register.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset, loads RESET_VALUE
//   load_i  - load enable
//   d_i     - next PC value
//   q_o     - current PC value
module pc_register
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_VALUE = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [31:0] d_i,
   output logic [31:0] q_o
);

   logic [31:0] pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_VALUE;
      end else if (load_i) begin
         pc_q <= d_i;
      end
   end

   assign q_o = pc_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM, one-entry hold buffer
// and the IF/ID pipeline register.
//
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   NextPC_In          - next PC from the PCPlus4/branch-target mux
//   Redirect           - NextPC_In is a taken-branch target; squash younger fetch
//   Stall              - decode cannot accept; IF/ID holds
//   PC_Out, PCPlus4    - current fetch PC and PC_Out + 4
//   IMem_Req/Addr      - instruction memory request (only in FETCH)
//   IMem_Ready         - request accepted this cycle
//   IMem_Valid/Data    - instruction memory response
//   IFID_Valid/Instr/PCPlus4 - IF/ID pipeline register
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] NextPC_In,
   input  logic        Redirect,
   input  logic        Stall,
   output logic [31:0] PC_Out,
   output logic [31:0] PCPlus4,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Ready,
   input  logic        IMem_Valid,
   input  logic [31:0] IMem_Data,
   output logic        IFID_Valid,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4
);

   fetch_state_e state_q, state_d;
   logic         pcLoad;
   logic         ifidValid_q, ifidValid_d;
   logic [31:0]  ifidInstr_q, ifidInstr_d;
   logic [31:0]  ifidPcPlus4_q, ifidPcPlus4_d;
   logic [31:0]  holdInstr_q, holdInstr_d;
   logic [31:0]  holdPcPlus4_q, holdPcPlus4_d;

   pc_register #(
      .RESET_VALUE (RESET_PC)
   ) u_pc_register (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (pcLoad),
      .d_i    (NextPC_In),
      .q_o    (PC_Out)
   );

   assign PCPlus4   = PC_Out + PC_INCREMENT;
   assign IMem_Req  = (state_q == FETCH);
   assign IMem_Addr = PC_Out;

   // Next-state logic. A redirect overrides everything else; the FSM only
   // enters DISCARD when a request for the squashed path is still in
   // flight. If that response arrives in the same cycle as a redirect
   // issued from DISCARD, it is consumed and the FSM returns to FETCH,
   // otherwise it would wait forever for a response that never comes.
   // The hold buffer needs no valid bit: its contents matter only in HOLD,
   // so leaving HOLD drops it.
   always_comb begin
      state_d       = state_q;
      pcLoad        = 1'b0;
      ifidValid_d   = ifidValid_q;
      ifidInstr_d   = ifidInstr_q;
      ifidPcPlus4_d = ifidPcPlus4_q;
      holdInstr_d   = holdInstr_q;
      holdPcPlus4_d = holdPcPlus4_q;

      if (Redirect) begin
         pcLoad      = 1'b1;
         ifidValid_d = 1'b0;
         case (state_q)
            FETCH:   state_d = IMem_Ready ? DISCARD : FETCH;
            WAIT:    state_d = IMem_Valid ? FETCH : DISCARD;
            DISCARD: state_d = IMem_Valid ? FETCH : DISCARD;
            default: state_d = FETCH;
         endcase
      end else begin
         case (state_q)
            FETCH: begin
               if (IMem_Ready) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (IMem_Valid && !Stall) begin
                  ifidValid_d   = 1'b1;
                  ifidInstr_d   = IMem_Data;
                  ifidPcPlus4_d = PCPlus4;
                  pcLoad        = 1'b1;
                  state_d       = FETCH;
               end else if (IMem_Valid) begin
                  holdInstr_d   = IMem_Data;
                  holdPcPlus4_d = PCPlus4;
                  state_d       = HOLD;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  ifidValid_d   = 1'b1;
                  ifidInstr_d   = holdInstr_q;
                  ifidPcPlus4_d = holdPcPlus4_q;
                  pcLoad        = 1'b1;
                  state_d       = FETCH;
               end
            end
            DISCARD: begin
               if (IMem_Valid) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         ifidValid_q   <= 1'b0;
         ifidInstr_q   <= 32'h0;
         ifidPcPlus4_q <= 32'h0;
         holdInstr_q   <= 32'h0;
         holdPcPlus4_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         ifidValid_q   <= ifidValid_d;
         ifidInstr_q   <= ifidInstr_d;
         ifidPcPlus4_q <= ifidPcPlus4_d;
         holdInstr_q   <= holdInstr_d;
         holdPcPlus4_q <= holdPcPlus4_d;
      end
   end

   assign IFID_Valid   = ifidValid_q;
   assign IFID_Instr   = ifidInstr_q;
   assign IFID_PCPlus4 = ifidPcPlus4_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios followed by
// randomized traffic, compared against a transaction-level model.
module tb_pc_fetch_stage;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] NextPC_In;
   logic        Redirect;
   logic        Stall;
   logic [31:0] PC_Out;
   logic [31:0] PCPlus4;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Ready;
   logic        IMem_Valid;
   logic [31:0] IMem_Data;
   logic        IFID_Valid;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PCPlus4;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model, described in terms of transactions rather than FSM
   // states: the PC, the IF/ID contents, an optional held instruction,
   // whether a request is in flight and whether its answer is unwanted.
   logic [31:0] mPc;
   logic        mIfValid;
   logic [31:0] mIfInstr;
   logic [31:0] mIfP4;
   logic        mBufValid;
   logic [31:0] mBufInstr;
   logic [31:0] mBufP4;
   logic        mInFlight;
   logic        mDiscard;

   pc_fetch_stage #(
      .RESET_PC (TB_RESET_PC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .NextPC_In    (NextPC_In),
      .Redirect     (Redirect),
      .Stall        (Stall),
      .PC_Out       (PC_Out),
      .PCPlus4      (PCPlus4),
      .IMem_Req     (IMem_Req),
      .IMem_Addr    (IMem_Addr),
      .IMem_Ready   (IMem_Ready),
      .IMem_Valid   (IMem_Valid),
      .IMem_Data    (IMem_Data),
      .IFID_Valid   (IFID_Valid),
      .IFID_Instr   (IFID_Instr),
      .IFID_PCPlus4 (IFID_PCPlus4)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Compare every visible output with the model.
   task automatic checkState();
      logic reqExp;
      reqExp = !mInFlight && !mBufValid;
      checkOutput("pc", PC_Out, mPc);
      checkOutput("pcplus4", PCPlus4, mPc + 32'd4);
      checkOutput("req", {31'b0, IMem_Req}, {31'b0, reqExp});
      if (reqExp) checkOutput("addr", IMem_Addr, mPc);
      checkOutput("ifid_valid", {31'b0, IFID_Valid}, {31'b0, mIfValid});
      checkOutput("ifid_instr", IFID_Instr, mIfInstr);
      checkOutput("ifid_pcplus4", IFID_PCPlus4, mIfP4);
   endtask

   // Advance the model by one clock given this cycle's inputs.
   task automatic modelStep(input logic rdy, input logic vld, input logic [31:0] data,
                            input logic st, input logic rd, input logic [31:0] npc);
      logic requesting, awaiting, squashing;
      logic [31:0] p4;
      requesting = !mInFlight && !mBufValid;
      awaiting   = mInFlight && !mDiscard;
      squashing  = mInFlight && mDiscard;
      p4         = mPc + 32'd4;
      if (rd) begin
         mPc       = npc;
         mIfValid  = 1'b0;
         mBufValid = 1'b0;
         if (requesting) begin
            mInFlight = rdy;
            mDiscard  = rdy;
         end else if (awaiting || squashing) begin
            if (vld) begin
               mInFlight = 1'b0;
               mDiscard  = 1'b0;
            end else begin
               mDiscard = 1'b1;
            end
         end
      end else if (requesting) begin
         if (rdy) begin
            mInFlight = 1'b1;
            mDiscard  = 1'b0;
         end
      end else if (awaiting) begin
         if (vld) begin
            mInFlight = 1'b0;
            if (!st) begin
               mIfValid = 1'b1;
               mIfInstr = data;
               mIfP4    = p4;
               mPc      = npc;
            end else begin
               mBufValid = 1'b1;
               mBufInstr = data;
               mBufP4    = p4;
            end
         end
      end else if (mBufValid) begin
         if (!st) begin
            mIfValid  = 1'b1;
            mIfInstr  = mBufInstr;
            mIfP4     = mBufP4;
            mPc       = npc;
            mBufValid = 1'b0;
         end
      end else if (squashing) begin
         if (vld) begin
            mInFlight = 1'b0;
            mDiscard  = 1'b0;
         end
      end
   endtask

   // Called at a falling edge: drive one cycle of inputs, advance the
   // model, then return at the next falling edge after checking.
   task automatic applyStimulus(input logic rdy, input logic vld, input logic [31:0] data,
                                input logic st, input logic rd, input logic [31:0] npc);
      IMem_Ready = rdy;
      IMem_Valid = vld;
      IMem_Data  = data;
      Stall      = st;
      Redirect   = rd;
      NextPC_In  = npc;
      modelStep(rdy, vld, data, st, rd, npc);
      @(posedge clk);
      @(negedge clk);
      checkState();
   endtask

   // Asynchronous reset pulse starting at a falling edge; outputs must
   // reach reset values without waiting for a clock edge.
   task automatic doReset();
      IMem_Ready = 1'b0;
      IMem_Valid = 1'b0;
      IMem_Data  = 32'h0;
      Stall      = 1'b0;
      Redirect   = 1'b0;
      NextPC_In  = 32'h0;
      rst_n      = 1'b0;
      #1;
      checkOutput("rst_pc", PC_Out, TB_RESET_PC);
      checkOutput("rst_ifid_valid", {31'b0, IFID_Valid}, 32'h0);
      checkOutput("rst_ifid_instr", IFID_Instr, 32'h0);
      checkOutput("rst_ifid_pcplus4", IFID_PCPlus4, 32'h0);
      checkOutput("rst_req", {31'b0, IMem_Req}, 32'h1);
      mPc       = TB_RESET_PC;
      mIfValid  = 1'b0;
      mIfInstr  = 32'h0;
      mIfP4     = 32'h0;
      mBufValid = 1'b0;
      mBufInstr = 32'h0;
      mBufP4    = 32'h0;
      mInFlight = 1'b0;
      mDiscard  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkState();
   endtask

   initial begin
      logic rdy, vld, st, rd;
      logic [31:0] npc;
      rst_n      = 1'b1;
      IMem_Ready = 1'b0;
      IMem_Valid = 1'b0;
      IMem_Data  = 32'h0;
      Stall      = 1'b0;
      Redirect   = 1'b0;
      NextPC_In  = 32'h0;
      @(negedge clk);
      doReset();
      checkOutput("first_addr", IMem_Addr, 32'h0);

      // Sequential fetch with a one-cycle memory.
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, mPc + 32'd4);
         applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, mPc + 32'd4);
         checkOutput("seq_addr", IMem_Addr, 32'(4 * k));
         checkOutput("seq_ifid_pcplus4", IFID_PCPlus4, 32'(4 * k));
      end

      // Stall while the response for PC 0x10 returns.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, mPc + 32'd4);
      applyStimulus(1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h10);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h14);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h14);
      checkOutput("hold_ifid_pcplus4", IFID_PCPlus4, 32'h10);
      checkOutput("hold_ifid_instr", IFID_Instr, 32'h1111_2222);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h14);
      checkOutput("hold_req", {31'b0, IMem_Req}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h14);
      checkOutput("release_instr", IFID_Instr, 32'hDEAD_BEEF);
      checkOutput("release_pcplus4", IFID_PCPlus4, 32'h14);

      // Redirect while waiting: the late response must be dropped.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h18);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
      checkOutput("redir_ifid_valid", {31'b0, IFID_Valid}, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h104);
      checkOutput("redir_addr", IMem_Addr, 32'h100);
      checkOutput("redir_drop", IFID_Instr, 32'hDEAD_BEEF);

      // PC wrap-around.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrap_pcplus4", PCPlus4, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, mPc + 32'd4);
      checkOutput("wrap_addr", IMem_Addr, 32'h0);
      checkOutput("wrap_ifid_pcplus4", IFID_PCPlus4, 32'h0);

      // Redirect and stall together while holding.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
      applyStimulus(1'b0, 1'b1, 32'hBEEF_0002, 1'b1, 1'b0, 32'h8);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
      checkOutput("hold_redir_valid", {31'b0, IFID_Valid}, 32'h0);
      checkOutput("hold_redir_pc", PC_Out, 32'h200);
      checkOutput("hold_redir_req", {31'b0, IMem_Req}, 32'h1);

      // Reset while a request is outstanding.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h204);
      doReset();
      checkOutput("restart_addr", IMem_Addr, TB_RESET_PC);

      // Randomized traffic; responses only while a request is in flight.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            doReset();
         end else begin
            rdy = ($urandom_range(0, 9) < 6);
            vld = mInFlight && ($urandom_range(0, 1) == 1);
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 9) == 0);
            npc = ($urandom_range(0, 9) < 8) ? (mPc + 32'd4) : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(rdy, vld, $urandom, st, rd, npc);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
